// File: rtl/mesh_job_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : mesh_job_scheduler_if
// Description : Handshake and bus bundle between the host/DMA side, the job
//               scheduler and the systolic mesh.
//               Host side  : job_valid/job_ready, w_valid/w_ready/w_data,
//                            res_valid/res_ready/res_data, busy
//               Mesh side  : mesh_start, mesh_pl_valid/addr/data, mesh_result
//               slave  modport = scheduler view, master modport = host/mesh view.
//               job_reuse exists only when MESH_SCHED_REUSE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface mesh_job_scheduler_if #(
    parameter int DW    = 8,
    parameter int ROWS  = 8,
    parameter int ROW_W = 3,
    parameter int COL_W = 5,
    parameter int ACC_W = 16
);
    logic                     job_valid;
    logic                     job_ready;
`ifdef MESH_SCHED_REUSE_EN
    logic                     job_reuse;
`endif
    logic                     w_valid;
    logic                     w_ready;
    logic [DW-1:0]            w_data;
    logic                     mesh_start;
    logic                     mesh_pl_valid;
    logic [ROW_W+COL_W-1:0]   mesh_pl_addr;
    logic [DW-1:0]            mesh_pl_data;
    logic [ROWS*ACC_W-1:0]    mesh_result;
    logic                     res_valid;
    logic                     res_ready;
    logic [ROWS*ACC_W-1:0]    res_data;
    logic                     busy;

    modport slave (
`ifdef MESH_SCHED_REUSE_EN
        input  job_reuse,
`endif
        input  job_valid,
        input  w_valid,
        input  w_data,
        input  mesh_result,
        input  res_ready,
        output job_ready,
        output w_ready,
        output mesh_start,
        output mesh_pl_valid,
        output mesh_pl_addr,
        output mesh_pl_data,
        output res_valid,
        output res_data,
        output busy
    );

    modport master (
`ifdef MESH_SCHED_REUSE_EN
        output job_reuse,
`endif
        output job_valid,
        output w_valid,
        output w_data,
        output mesh_result,
        output res_ready,
        input  job_ready,
        input  w_ready,
        input  mesh_start,
        input  mesh_pl_valid,
        input  mesh_pl_addr,
        input  mesh_pl_data,
        input  res_valid,
        input  res_data,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mesh_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mesh_job_scheduler
// Description : Runs one matrix-vector job on the systolic mesh: streams a
//               ROWS x COLS weight tile into the preload port (row-major),
//               pulses mesh_start, waits RUN_CYCLES, then holds the captured
//               mesh result behind a valid/ready handshake.
// Ports       : clk, rst (synchronous, active high)
//               bus (mesh_job_scheduler_if.slave) - job, weight stream,
//               preload, start, result and busy signals.
// Option      : MESH_SCHED_REUSE_EN - adds job_reuse; a reuse job skips the
//               tile load when a full tile has been loaded since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_job_scheduler #(
    parameter int DW         = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 32,
    parameter int ROW_W      = 3,
    parameter int COL_W      = 5,
    parameter int ACC_W      = 16,
    parameter int RUN_CYCLES = 40,
    parameter int RUN_W      = 6
) (
    input  wire logic              clk,
    input  wire logic              rst,
    mesh_job_scheduler_if.slave    bus
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   state;
    logic [ROW_W-1:0]         row;
    logic [COL_W-1:0]         col;
    logic [RUN_W-1:0]         run_cnt;

    // Registered copies of every output; they are updated in the same
    // always_ff as the state so they always agree with it.
    logic                     job_ready_q;
    logic                     w_ready_q;
    logic                     start_q;
    logic                     pl_valid_q;
    logic [ROW_W+COL_W-1:0]   pl_addr_q;
    logic [DW-1:0]            pl_data_q;
    logic                     res_valid_q;
    logic [ROWS*ACC_W-1:0]    res_data_q;
    logic                     busy_q;
`ifdef MESH_SCHED_REUSE_EN
    logic                     loaded;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            row         <= '0;
            col         <= '0;
            run_cnt     <= '0;
            job_ready_q <= 1'b1;
            w_ready_q   <= 1'b0;
            start_q     <= 1'b0;
            pl_valid_q  <= 1'b0;
            pl_addr_q   <= '0;
            pl_data_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
`ifdef MESH_SCHED_REUSE_EN
            loaded      <= 1'b0;
`endif
        end else begin
            // Strobes default low; they are raised for exactly one cycle.
            start_q    <= 1'b0;
            pl_valid_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.job_valid) begin
                        row         <= '0;
                        col         <= '0;
                        job_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
`ifdef MESH_SCHED_REUSE_EN
                        if (bus.job_reuse && loaded) begin
                            state <= S_START;
                        end else begin
                            state     <= S_LOAD;
                            w_ready_q <= 1'b1;
                        end
`else
                        state     <= S_LOAD;
                        w_ready_q <= 1'b1;
`endif
                    end
                end

                S_LOAD: begin
                    if (bus.w_valid && w_ready_q) begin
                        pl_valid_q <= 1'b1;
                        pl_addr_q  <= {row, col};
                        pl_data_q  <= bus.w_data;
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                // Last beat: the write appears next cycle,
                                // while START runs, so mesh_start trails it.
                                state     <= S_START;
                                w_ready_q <= 1'b0;
`ifdef MESH_SCHED_REUSE_EN
                                loaded    <= 1'b1;
`endif
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end

                S_START: begin
                    start_q <= 1'b1;
                    run_cnt <= '0;
                    state   <= S_RUN;
                end

                S_RUN: begin
                    // Counter is 0 in the mesh_start cycle, so the result is
                    // valid exactly RUN_CYCLES cycles after the pulse.
                    if (run_cnt == RUN_LAST) begin
                        res_data_q  <= bus.mesh_result;
                        res_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        job_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    job_ready_q <= 1'b1;
                    w_ready_q   <= 1'b0;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.job_ready     = job_ready_q;
    assign bus.w_ready       = w_ready_q;
    assign bus.mesh_start    = start_q;
    assign bus.mesh_pl_valid = pl_valid_q;
    assign bus.mesh_pl_addr  = pl_addr_q;
    assign bus.mesh_pl_data  = pl_data_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_data      = res_data_q;
    assign bus.busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mesh_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesh_job_scheduler
// Description : Directed self-checking bench for mesh_job_scheduler: basic
//               job, stalled weight stream, result backpressure, reset in
//               the middle of a load, ignored inputs and (with
//               MESH_SCHED_REUSE_EN) tile reuse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_job_scheduler;

    localparam int DW         = 8;
    localparam int ROWS       = 8;
    localparam int COLS       = 32;
    localparam int ROW_W      = 3;
    localparam int COL_W      = 5;
    localparam int ACC_W      = 16;
    localparam int RUN_CYCLES = 40;
    localparam int RUN_W      = 6;
    localparam int RW         = ROWS * ACC_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mesh_job_scheduler_if #(
        .DW(DW), .ROWS(ROWS), .ROW_W(ROW_W), .COL_W(COL_W), .ACC_W(ACC_W)
    ) mif ();

    mesh_job_scheduler #(
        .DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W),
        .ACC_W(ACC_W), .RUN_CYCLES(RUN_CYCLES), .RUN_W(RUN_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int wr_cnt      = 0;
    int last_wr_cyc = 0;
    int start_cnt   = 0;
    int start_cyc   = 0;

    // Mesh result changes every cycle, so a capture on the wrong cycle shows.
    function automatic logic [RW-1:0] pat(input int k);
        logic [RW-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[r*ACC_W +: ACC_W] = 16'(k * 7 + r * 4099);
        return v;
    endfunction

    initial begin
        mif.mesh_result = pat(0);
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mif.mesh_result = pat(cyc);
        end
    end

    always @(negedge clk) begin
        if (mif.mesh_pl_valid === 1'b1) begin
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (mif.mesh_start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job();
        mif.job_valid = 1'b1;
        tick();
        mif.job_valid = 1'b0;
    endtask

    // Streams beats until stop_at have been accepted. stall=1 drives the
    // w_valid pattern 1,0,0,1. Each cycle's write strobe, address and data
    // are compared with what the previous cycle's handshake implies.
    task automatic load_tile(input int stall, input logic [7:0] xr, input int stop_at,
                             output int errs);
        int   beat;
        int   j;
        logic rdy;
        logic v;
        beat = 0;
        j    = 0;
        errs = 0;
        while (beat < stop_at && j < 4000) begin
            rdy = mif.w_ready;
            v   = (stall == 0) ? 1'b1 : ((j % 4 == 0) || (j % 4 == 3));
            mif.w_valid = v;
            mif.w_data  = 8'(beat) ^ xr;
            tick();
            if (mif.mesh_pl_valid !== (v && rdy)) errs++;
            if (v && rdy) begin
                if (mif.mesh_pl_addr !== 8'(beat)) errs++;
                if (mif.mesh_pl_data !== (8'(beat) ^ xr)) errs++;
                beat++;
            end
            j++;
        end
        mif.w_valid = 1'b0;
        if (beat < stop_at) errs++;
    endtask

    task automatic wait_result(output int vc);
        int n;
        n = 0;
        while (mif.res_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("res_valid_timeout", RW'(mif.res_valid), RW'(1));
        vc = cyc;
    endtask

    task automatic handshake();
        mif.res_ready = 1'b1;
        tick();
        mif.res_ready = 1'b0;
    endtask

    initial begin
        int            e;
        int            s0;
        int            vc;
        int            bp_err;
        logic [RW-1:0] cap;

        mif.job_valid = 1'b0;
        mif.w_valid   = 1'b0;
        mif.w_data    = '0;
        mif.res_ready = 1'b0;
`ifdef MESH_SCHED_REUSE_EN
        mif.job_reuse = 1'b0;
`endif

        // ---------------- reset state ----------------
        rst = 1'b1;
        tick();
        tick();
        check("rst_job_ready", RW'(mif.job_ready), RW'(1));
        check("rst_w_ready",   RW'(mif.w_ready), RW'(0));
        check("rst_busy",      RW'(mif.busy), RW'(0));
        check("rst_start",     RW'(mif.mesh_start), RW'(0));
        check("rst_pl_valid",  RW'(mif.mesh_pl_valid), RW'(0));
        check("rst_pl_addr",   RW'(mif.mesh_pl_addr), RW'(0));
        check("rst_res_valid", RW'(mif.res_valid), RW'(0));
        check("rst_res_data",  mif.res_data, RW'(0));
        rst = 1'b0;

        // ---------------- w_valid in IDLE is ignored ----------------
        mif.w_valid = 1'b1;
        repeat (3) tick();
        check("idle_w_ready",  RW'(mif.w_ready), RW'(0));
        check("idle_no_write", RW'(wr_cnt), RW'(0));
        mif.w_valid = 1'b0;

        // ---------------- basic job ----------------
        start_job();
        check("acc_job_ready", RW'(mif.job_ready), RW'(0));
        check("acc_w_ready",   RW'(mif.w_ready), RW'(1));
        check("acc_busy",      RW'(mif.busy), RW'(1));
        load_tile(0, 8'h00, 256, e);
        check("basic_beats",   RW'(e), RW'(0));
        check("basic_wr_cnt",  RW'(wr_cnt), RW'(256));
        check("basic_w_ready_drop", RW'(mif.w_ready), RW'(0));
        check("basic_no_early_start", RW'(start_cnt), RW'(0));
        tick();
        check("basic_start",   RW'(mif.mesh_start), RW'(1));
        check("basic_start_gap", RW'(start_cyc - last_wr_cyc), RW'(1));
        mif.job_valid = 1'b1;               // held through RUN and DONE
        wait_result(vc);
        mif.job_valid = 1'b0;
        check("basic_latency", RW'(vc - start_cyc), RW'(RUN_CYCLES));
        cap = pat(vc - 1);
        check("basic_res_data", mif.res_data, cap);
        check("run_ignore_job_start", RW'(start_cnt), RW'(1));
        check("run_ignore_job_wr",    RW'(wr_cnt), RW'(256));

        // ---------------- result backpressure ----------------
        bp_err = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mif.res_valid !== 1'b1) bp_err++;
            if (mif.res_data !== cap) bp_err++;
            if (mif.job_ready !== 1'b0) bp_err++;
        end
        check("bp_stable", RW'(bp_err), RW'(0));
        handshake();
        check("bp_res_valid_low", RW'(mif.res_valid), RW'(0));
        check("bp_job_ready",     RW'(mif.job_ready), RW'(1));
        check("bp_busy_low",      RW'(mif.busy), RW'(0));
        check("bp_res_data_held", mif.res_data, cap);

        // ---------------- stalled stream ----------------
        start_job();
        load_tile(1, 8'h5A, 256, e);
        check("stall_beats",    RW'(e), RW'(0));
        check("stall_wr_cnt",   RW'(wr_cnt), RW'(512));
        check("stall_no_early_start", RW'(start_cnt), RW'(1));
        tick();
        check("stall_start",    RW'(mif.mesh_start), RW'(1));
        check("stall_start_gap", RW'(start_cyc - last_wr_cyc), RW'(1));
        wait_result(vc);
        check("stall_latency",  RW'(vc - start_cyc), RW'(RUN_CYCLES));
        check("stall_res_data", mif.res_data, pat(vc - 1));
        handshake();

        // ---------------- reset mid-LOAD at beat 100 ----------------
        start_job();
        load_tile(0, 8'h33, 100, e);
        check("mid_beats", RW'(e), RW'(0));
        mif.w_valid = 1'b1;
        mif.w_data  = 8'h99;
        rst = 1'b1;
        tick();
        check("mid_rst_job_ready", RW'(mif.job_ready), RW'(1));
        check("mid_rst_w_ready",   RW'(mif.w_ready), RW'(0));
        check("mid_rst_busy",      RW'(mif.busy), RW'(0));
        check("mid_rst_pl_valid",  RW'(mif.mesh_pl_valid), RW'(0));
        check("mid_rst_pl_addr",   RW'(mif.mesh_pl_addr), RW'(0));
        check("mid_rst_pl_data",   RW'(mif.mesh_pl_data), RW'(0));
        check("mid_rst_res_valid", RW'(mif.res_valid), RW'(0));
        check("mid_rst_res_data",  mif.res_data, RW'(0));
        rst = 1'b0;
        mif.w_valid = 1'b0;
        check("mid_wr_cnt", RW'(wr_cnt), RW'(612));

        // ---------------- fresh job restarts at address 0 ----------------
`ifdef MESH_SCHED_REUSE_EN
        mif.job_reuse = 1'b1;               // no tile since reset: full load
`endif
        start_job();
        check("restart_w_ready", RW'(mif.w_ready), RW'(1));
        load_tile(0, 8'hC3, 256, e);
        check("restart_beats",  RW'(e), RW'(0));
        check("restart_wr_cnt", RW'(wr_cnt), RW'(868));
        tick();
        check("restart_start",  RW'(mif.mesh_start), RW'(1));
        wait_result(vc);
        check("restart_res_data", mif.res_data, pat(vc - 1));
        handshake();

`ifdef MESH_SCHED_REUSE_EN
        // ---------------- reuse of the loaded tile ----------------
        s0 = wr_cnt;
        mif.job_reuse = 1'b1;
        start_job();
        mif.job_reuse = 1'b0;
        check("reuse_w_ready", RW'(mif.w_ready), RW'(0));
        check("reuse_busy",    RW'(mif.busy), RW'(1));
        tick();
        check("reuse_start",   RW'(mif.mesh_start), RW'(1));
        wait_result(vc);
        check("reuse_latency", RW'(vc - start_cyc), RW'(RUN_CYCLES));
        check("reuse_no_write", RW'(wr_cnt), RW'(s0));
        check("reuse_res_data", mif.res_data, pat(vc - 1));
        handshake();
`else
        s0 = wr_cnt;
        check("final_wr_cnt", RW'(s0), RW'(868));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
